// File: rtl/apb_cmd_master.sv
// APB3/APB4 requester: turns a valid/ready command into one APB transfer and
// returns read data and status on a held response port.
module apb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk_i,
  input  logic        presetn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_strb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             psel_nxt, penable_nxt;
  logic             pwrite_nxt;
  logic [31:0]      paddr_nxt, pwdata_nxt;
  logic [3:0]       pstrb_nxt;
  logic             rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [31:0]      rsp_rdata_nxt;
  logic             accept;
  logic             timeout_hit;

  // Ready is held low during reset even though the state already reads IDLE.
  assign req_ready_o = presetn_i & (state == ST_IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CNT);

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    psel_nxt        = psel_o;
    penable_nxt     = penable_o;
    pwrite_nxt      = pwrite_o;
    paddr_nxt       = paddr_o;
    pwdata_nxt      = pwdata_o;
    pstrb_nxt       = pstrb_o;
    rsp_valid_nxt   = rsp_valid_o;
    rsp_err_nxt     = rsp_err_o;
    rsp_timeout_nxt = rsp_timeout_o;
    rsp_rdata_nxt   = rsp_rdata_o;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          paddr_nxt  = req_addr_i;
          pwrite_nxt = req_write_i;
          pwdata_nxt = req_wdata_i;
          pstrb_nxt  = req_write_i ? req_strb_i : 4'b0000;
          if (req_addr_i[1:0] != 2'b00) begin
            // Misaligned commands are answered locally without touching the bus.
            state_nxt       = ST_RESP;
            rsp_valid_nxt   = 1'b1;
            rsp_err_nxt     = 1'b1;
            rsp_timeout_nxt = 1'b0;
            rsp_rdata_nxt   = 32'h0;
          end else begin
            state_nxt   = ST_SETUP;
            psel_nxt    = 1'b1;
            penable_nxt = 1'b0;
          end
        end
      end

      ST_SETUP: begin
        state_nxt    = ST_ACCESS;
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
      end

      ST_ACCESS: begin
        // The timeout wins over a pready arriving in the same cycle.
        if (timeout_hit) begin
          state_nxt       = ST_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = 32'h0;
        end else if (pready_i) begin
          state_nxt       = ST_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = pslverr_i;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = pwrite_o ? 32'h0 : prdata_i;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_nxt       = ST_IDLE;
          rsp_valid_nxt   = 1'b0;
          rsp_err_nxt     = 1'b0;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = 32'h0;
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= 32'h0;
      pwdata_o      <= 32'h0;
      pstrb_o       <= 4'b0000;
      rsp_valid_o   <= 1'b0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      rsp_rdata_o   <= 32'h0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_cnt_nxt;
      psel_o        <= psel_nxt;
      penable_o     <= penable_nxt;
      pwrite_o      <= pwrite_nxt;
      paddr_o       <= paddr_nxt;
      pwdata_o      <= pwdata_nxt;
      pstrb_o       <= pstrb_nxt;
      rsp_valid_o   <= rsp_valid_nxt;
      rsp_err_o     <= rsp_err_nxt;
      rsp_timeout_o <= rsp_timeout_nxt;
      rsp_rdata_o   <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized bench for apb_cmd_master with a transaction-level expectation
// model and a scripted APB slave.
module tb_apb_cmd_master;

  localparam int TO = 16;

  logic        pclk_i = 1'b0;
  logic        presetn_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_strb_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
  logic [3:0]  pstrb_o;

  int checks   = 0;
  int failures = 0;

  apb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .pclk_i(pclk_i), .presetn_i(presetn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One command end to end; the slave answers on ACCESS cycle number 'waits'.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input int waits, input logic slverr,
                               input logic [31:0] rdata, input int rspDelay);
    logic        mis, expTo, expErr, seen, firstSel, hWrite;
    logic [31:0] expRdata, hAddr, hWdata;
    logic [3:0]  hStrb;
    int          expAccess, expLat, lat, setupCnt, accessCnt, unstable, guard;

    mis       = (addr[1:0] != 2'b00);
    expTo     = !mis && (waits >= TO);
    expErr    = mis || expTo || slverr;
    expRdata  = (mis || expTo || wr) ? 32'h0 : rdata;
    expAccess = mis ? 0 : (expTo ? TO + 1 : waits + 1);
    expLat    = mis ? 0 : expAccess + 1;

    setupCnt = 0; accessCnt = 0; unstable = 0; lat = -1;
    seen = 1'b0; firstSel = 1'b1;
    hAddr = '0; hWdata = '0; hStrb = '0; hWrite = 1'b0;

    @(negedge pclk_i);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr;
    req_wdata_i = wdata; req_strb_i = strb;
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(negedge pclk_i);
      guard++;
    end
    checkOutput("req_ready_before_accept", req_ready_o, 1);
    if (!req_ready_o) begin
      req_valid_i = 1'b0;
      return;
    end
    @(posedge pclk_i);
    @(negedge pclk_i);
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_strb_i  = 4'($urandom);
    req_write_i = 1'($urandom);

    for (int k = 0; k < 100 && !seen; k++) begin
      if (k > 0) @(negedge pclk_i);
      if (rsp_valid_o) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        if (psel_o) begin
          if (!penable_o) setupCnt++;
          if (firstSel) begin
            hAddr = paddr_o; hWrite = pwrite_o; hWdata = pwdata_o; hStrb = pstrb_o;
            firstSel = 1'b0;
          end else if (paddr_o !== hAddr || pwrite_o !== hWrite ||
                       pwdata_o !== hWdata || pstrb_o !== hStrb) begin
            unstable++;
          end
        end else if (penable_o) begin
          unstable++;
        end
        if (psel_o && penable_o) begin
          pready_i  = (accessCnt == waits);
          pslverr_i = pready_i ? slverr : 1'($urandom);
          prdata_i  = pready_i ? rdata : $urandom;
          accessCnt++;
        end else begin
          pready_i  = 1'($urandom);
          pslverr_i = 1'($urandom);
          prdata_i  = $urandom;
        end
      end
    end

    checkOutput("rsp_seen", seen, 1);
    checkOutput("rsp_latency", lat, expLat);
    checkOutput("setup_cycles", setupCnt, mis ? 0 : 1);
    checkOutput("access_cycles", accessCnt, expAccess);
    checkOutput("apb_stable", unstable, 0);
    checkOutput("psel_in_resp", {psel_o, penable_o}, 0);
    if (!mis) begin
      checkOutput("paddr", hAddr, addr);
      checkOutput("pwrite", hWrite, wr);
      checkOutput("pwdata", hWdata, wdata);
      checkOutput("pstrb", hStrb, wr ? strb : 4'b0000);
    end
    checkOutput("rsp_err", rsp_err_o, expErr);
    checkOutput("rsp_timeout", rsp_timeout_o, expTo);
    checkOutput("rsp_rdata", rsp_rdata_o, expRdata);

    for (int i = 0; i < rspDelay; i++) begin
      @(negedge pclk_i);
      checkOutput("rsp_hold", {rsp_valid_o, rsp_err_o, rsp_timeout_o, req_ready_o},
                  {1'b1, expErr, expTo, 1'b0});
    end
    rsp_ready_i = 1'b1;
    @(posedge pclk_i);
    @(negedge pclk_i);
    rsp_ready_i = 1'b0;
    checkOutput("rsp_cleared", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 0);
    checkOutput("idle_ready", req_ready_o, 1);
    checkOutput("paddr_hold_idle", paddr_o, addr);
  endtask

  task automatic resetMidAccess();
    @(negedge pclk_i);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h10;
    req_wdata_i = 32'h0; req_strb_i = 4'hF;
    pready_i = 1'b0;
    @(posedge pclk_i);
    @(negedge pclk_i);
    req_valid_i = 1'b0;
    @(negedge pclk_i);
    checkOutput("t6_in_access", {psel_o, penable_o}, 2'b11);
    #2 presetn_i = 1'b0;
    #1;
    checkOutput("t6_async_drop", {psel_o, penable_o, rsp_valid_o, req_ready_o}, 0);
    repeat (2) @(negedge pclk_i);
    checkOutput("t6_held_reset", {psel_o, penable_o, rsp_valid_o}, 0);
    presetn_i = 1'b1;
    @(negedge pclk_i);
    checkOutput("t6_after_release", {psel_o, rsp_valid_o, req_ready_o}, 3'b001);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        wr, sl;
    logic [31:0] addr;
    int          waits, sel;

    presetn_i = 1'b0;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_strb_i = '0; rsp_ready_i = 1'b0;
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    #2;
    checkOutput("reset_ctrl", {req_ready_o, psel_o, penable_o, pwrite_o,
                               rsp_valid_o, rsp_err_o, rsp_timeout_o}, 0);
    checkOutput("reset_paddr", paddr_o, 0);
    checkOutput("reset_data", pwdata_o | rsp_rdata_o | 32'(pstrb_o), 0);
    repeat (3) @(negedge pclk_i);
    presetn_i = 1'b1;

    $display("[TB] T1 zero-wait write");
    applyStimulus(1'b1, 32'h0000, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0, 0);
    $display("[TB] T2 read with 3 wait states");
    applyStimulus(1'b0, 32'h0004, 32'h0, 4'hF, 3, 1'b0, 32'h0000_0001, 1);
    $display("[TB] T3 read timeout");
    applyStimulus(1'b0, 32'h0008, 32'h0, 4'h0, 1000, 1'b0, 32'hDEAD_BEEF, 0);
    $display("[TB] T3b pready on the timeout cycle is ignored");
    applyStimulus(1'b0, 32'h000C, 32'h0, 4'h0, TO, 1'b0, 32'h1234_5678, 0);
    $display("[TB] T3c pready on the last wait cycle completes");
    applyStimulus(1'b0, 32'h0010, 32'h0, 4'h0, TO - 1, 1'b0, 32'hCAFE_F00D, 0);
    $display("[TB] T4 misaligned write");
    applyStimulus(1'b1, 32'h0006, 32'hA5A5_A5A5, 4'h3, 0, 1'b0, 32'h0, 0);
    $display("[TB] T5 slave error with held response");
    applyStimulus(1'b1, 32'h0020, 32'h1357_9BDF, 4'hC, 0, 1'b1, 32'h0, 5);
    $display("[TB] T5b read error still returns data");
    applyStimulus(1'b0, 32'h0024, 32'h0, 4'h0, 2, 1'b1, 32'h0BAD_0BAD, 2);
    $display("[TB] T6 reset during access");
    resetMidAccess();
    applyStimulus(1'b1, 32'h0040, 32'h0F0F_0F0F, 4'h5, 1, 1'b0, 32'h0, 0);

    $display("[TB] random commands");
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom);
      addr = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      sel   = $urandom_range(0, 9);
      waits = (sel < 7) ? $urandom_range(0, 5) : $urandom_range(TO - 2, TO + 2);
      sl    = ($urandom_range(0, 3) == 0);
      applyStimulus(wr, addr, $urandom, 4'($urandom), waits, sl, $urandom,
                    $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
